// File: rtl/pulse_period_meter.sv
// pulse_period_meter: qualifies zero-crossing pulses and measures clk cycles per
// revolution, publishing each period on a valid/ready interface with stall/overrun flags.
module pulse_period_meter #(
    parameter int unsigned CNT_WIDTH     = 24,
    parameter int unsigned HOLDOFF       = 16,
    parameter int unsigned EDGES_PER_REV = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pulse,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    input  logic                 period_ready,
    output logic                 stalled,
    output logic                 overrun
);
    localparam int unsigned HW = $clog2(HOLDOFF + 1);
    localparam int unsigned EW = (EDGES_PER_REV > 1) ? $clog2(EDGES_PER_REV) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [HW-1:0]        HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [EW-1:0]        LAST_EDGE = EW'(EDGES_PER_REV - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [EW-1:0]        edge_cnt, edge_cnt_n;
    logic [HW-1:0]        holdoff_cnt, holdoff_n;
    logic [CNT_WIDTH-1:0] period_n;
    logic                 valid_n, stalled_n, overrun_n;
    logic                 pulse_q;
    logic                 raw_edge, accepted;

    // pulse_q resets high so a pulse held through reset release is not an edge
    assign raw_edge = pulse & ~pulse_q;
    assign accepted = raw_edge & (holdoff_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            edge_cnt     <= '0;
            holdoff_cnt  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            overrun      <= 1'b0;
            pulse_q      <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            edge_cnt     <= edge_cnt_n;
            holdoff_cnt  <= holdoff_n;
            period       <= period_n;
            period_valid <= valid_n;
            stalled      <= stalled_n;
            overrun      <= overrun_n;
            pulse_q      <= pulse;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        edge_cnt_n = edge_cnt;
        holdoff_n  = holdoff_cnt;
        period_n   = period;
        valid_n    = period_valid;
        stalled_n  = stalled;
        overrun_n  = overrun;

        if (accepted) begin
            holdoff_n = HOLD_LOAD;
        end else if (holdoff_cnt != '0) begin
            holdoff_n = holdoff_cnt - HW'(1);
        end

        // a publish in the same cycle as a transfer overrides the valid drop below
        if (period_valid && period_ready) begin
            valid_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (accepted) begin
                    state_n    = MEASURE;
                    cnt_n      = CNT_ONE;
                    edge_cnt_n = '0;
                end
            end
            MEASURE: begin
                if (accepted) begin
                    if (edge_cnt == LAST_EDGE) begin
                        period_n   = cnt;
                        valid_n    = 1'b1;
                        overrun_n  = overrun | (period_valid & ~period_ready);
                        cnt_n      = CNT_ONE;
                        edge_cnt_n = '0;
                    end else begin
                        edge_cnt_n = edge_cnt + EW'(1);
                        // saturate so an intermediate edge at full scale cannot wrap
                        cnt_n      = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    end
                end else if (cnt == CNT_MAX) begin
                    state_n   = STALLED;
                    stalled_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STALLED: begin
                if (accepted) begin
                    state_n    = MEASURE;
                    cnt_n      = CNT_ONE;
                    edge_cnt_n = '0;
                    stalled_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
